// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Brief    : Shared encodings and default latencies for the pipeline control.
// Revision : 1.0
// ============================================================================
package cpu_pkg;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EXE = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    typedef enum logic [0:0] {
        RUN     = 1'b0,
        MD_WAIT = 1'b1
    } hz_state_t;

    localparam int DEF_MULT_LAT    = 4;
    localparam int DEF_DIV_LAT     = 32;
    localparam int DEF_MEM_TIMEOUT = 255;

endpackage
`default_nettype wire

// File: rtl/fwd_sel.sv
`default_nettype none
// ============================================================================
// Module   : fwd_sel
// Brief    : Forwarding source select for one DEC read port (EXE > MEM > WB).
// Revision : 1.0
// ============================================================================
module fwd_sel
    import cpu_pkg::*;
(
    input  logic [4:0] i_ra,
    input  logic [4:0] i_wra_e,
    input  logic       i_reg_we_e,
    input  logic       i_is_load_e,
    input  logic [4:0] i_wra_m,
    input  logic       i_reg_we_m,
    input  logic [4:0] i_wra_w,
    input  logic       i_reg_we_w,
    output logic [1:0] o_fwd
);

    // A load in EXE has no data yet, so it falls through to older stages.
    always_comb begin
        o_fwd = FWD_RF;
        if (i_ra != 5'd0) begin
            if (i_reg_we_e && !i_is_load_e && (i_wra_e == i_ra)) begin
                o_fwd = FWD_EXE;
            end else if (i_reg_we_m && (i_wra_m == i_ra)) begin
                o_fwd = FWD_MEM;
            end else if (i_reg_we_w && (i_wra_w == i_ra)) begin
                o_fwd = FWD_WB;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Forwarding, load-use, branch squash, mult/div and dMem freeze control.
// Revision : 1.0
// ============================================================================
module hazard_ctrl
    import cpu_pkg::*;
#(
    parameter int MULT_LAT    = DEF_MULT_LAT,
    parameter int DIV_LAT     = DEF_DIV_LAT,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
)(
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] i_ra1,
    input  logic [4:0] i_ra2,
    input  logic       i_use1,
    input  logic       i_use2,
    input  logic [4:0] i_WRAE,
    input  logic       i_regWeE,
    input  logic       i_isLoadE,
    input  logic [4:0] i_WRAM,
    input  logic       i_regWeM,
    input  logic [4:0] i_WRAW,
    input  logic       i_regWeW,
    input  logic       i_brTakenE,
    input  logic       i_mdStartE,
    input  logic       i_mdDivE,
    input  logic       i_dMemReq,
    input  logic       i_dMemReady,
    output logic [1:0] o_fwdA,
    output logic [1:0] o_fwdB,
    output logic       o_stallIF,
    output logic       o_stallDEC,
    output logic       o_stallEXE,
    output logic       o_stallMEM,
    output logic       o_flushDEC,
    output logic       o_flushEXE,
    output logic       o_flushMEM,
    output logic       o_flushWB,
    output logic       o_mdBusy,
    output logic       o_mdDone,
    output logic       o_memErr
);

    localparam int MD_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int MD_W   = $clog2(MD_MAX);
    localparam int WC_W   = $clog2(MEM_TIMEOUT + 1);

    localparam logic [MD_W-1:0] C_MUL_LOAD   = MD_W'(MULT_LAT - 2);
    localparam logic [MD_W-1:0] C_DIV_LOAD   = MD_W'(DIV_LAT - 2);
    localparam logic [WC_W-1:0] C_TIMEOUT    = WC_W'(MEM_TIMEOUT);
    localparam logic [WC_W-1:0] C_TIMEOUT_M1 = WC_W'(MEM_TIMEOUT - 1);

    hz_state_t       r_state;
    logic [MD_W-1:0] r_md_cnt;
    logic [WC_W-1:0] r_wait_cnt;
    logic            r_mem_err;

    logic       w_mem_stall;
    logic       w_run;
    logic       w_md_wait;
    logic       w_md_last;
    logic       w_md_go;
    logic       w_md_stall;
    logic       w_branch;
    logic       w_src_hit;
    logic       w_load_use;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;

    fwd_sel u_fwd_a (
        .i_ra        (i_ra1),
        .i_wra_e     (i_WRAE),
        .i_reg_we_e  (i_regWeE),
        .i_is_load_e (i_isLoadE),
        .i_wra_m     (i_WRAM),
        .i_reg_we_m  (i_regWeM),
        .i_wra_w     (i_WRAW),
        .i_reg_we_w  (i_regWeW),
        .o_fwd       (w_fwd_a)
    );

    fwd_sel u_fwd_b (
        .i_ra        (i_ra2),
        .i_wra_e     (i_WRAE),
        .i_reg_we_e  (i_regWeE),
        .i_is_load_e (i_isLoadE),
        .i_wra_m     (i_WRAM),
        .i_reg_we_m  (i_regWeM),
        .i_wra_w     (i_WRAW),
        .i_reg_we_w  (i_regWeW),
        .o_fwd       (w_fwd_b)
    );

    assign w_mem_stall = i_dMemReq & ~i_dMemReady;
    assign w_run       = (r_state == RUN);
    assign w_md_wait   = (r_state == MD_WAIT);
    assign w_md_last   = w_md_wait & (r_md_cnt == '0);
    assign w_md_go     = w_run & i_mdStartE & ~i_brTakenE & ~w_mem_stall;
    // The issue cycle already holds EXE, so occupancy = issue cycle + MD_WAIT cycles.
    assign w_md_stall  = w_md_go | (w_md_wait & ~w_md_last);
    assign w_branch    = w_run & i_brTakenE;
    assign w_src_hit   = (i_use1 & (i_ra1 == i_WRAE)) | (i_use2 & (i_ra2 == i_WRAE));
    assign w_load_use  = w_run & i_isLoadE & (i_WRAE != 5'd0) & w_src_hit
                       & ~i_brTakenE & ~w_md_go;

    always_comb begin
        o_fwdA     = 2'd0;
        o_fwdB     = 2'd0;
        o_stallIF  = 1'b0;
        o_stallDEC = 1'b0;
        o_stallEXE = 1'b0;
        o_stallMEM = 1'b0;
        o_flushDEC = 1'b0;
        o_flushEXE = 1'b0;
        o_flushMEM = 1'b0;
        o_flushWB  = 1'b0;
        o_mdBusy   = 1'b0;
        o_mdDone   = 1'b0;
        o_memErr   = 1'b0;
        if (!rst) begin
            o_fwdA     = w_fwd_a;
            o_fwdB     = w_fwd_b;
            o_stallIF  = w_mem_stall | w_md_stall | w_load_use;
            o_stallDEC = w_mem_stall | w_md_stall | w_load_use;
            o_stallEXE = w_mem_stall | w_md_stall;
            o_stallMEM = w_mem_stall;
            o_flushDEC = ~w_mem_stall & w_branch;
            o_flushEXE = ~w_mem_stall & (w_branch | w_load_use);
            o_flushMEM = ~w_mem_stall & w_md_stall;
            o_flushWB  = w_mem_stall;
            o_mdBusy   = w_md_wait;
            o_mdDone   = w_md_last;
            o_memErr   = r_mem_err;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_md_cnt   <= '0;
            r_wait_cnt <= '0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_md_go) begin
                        r_state  <= MD_WAIT;
                        r_md_cnt <= i_mdDivE ? C_DIV_LOAD : C_MUL_LOAD;
                    end
                end
                MD_WAIT: begin
                    if (w_md_last) begin
                        r_state <= RUN;
                    end else begin
                        r_md_cnt <= r_md_cnt - MD_W'(1);
                    end
                end
                default: r_state <= RUN;
            endcase

            if (w_mem_stall) begin
                if (r_wait_cnt != C_TIMEOUT) begin
                    r_wait_cnt <= r_wait_cnt + WC_W'(1);
                end
                if (r_wait_cnt == C_TIMEOUT_M1) begin
                    r_mem_err <= 1'b1;
                end
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Directed bench for hazard_ctrl with a cycle-level behavioural model.
// Revision : 1.0
// ============================================================================
module tb_hazard_ctrl;

    localparam int MUL_L = 4;
    localparam int DIV_L = 32;
    localparam int TMO   = 255;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] i_ra1, i_ra2, i_WRAE, i_WRAM, i_WRAW;
    logic       i_use1, i_use2, i_regWeE, i_isLoadE, i_regWeM, i_regWeW;
    logic       i_brTakenE, i_mdStartE, i_mdDivE, i_dMemReq, i_dMemReady;
    logic [1:0] o_fwdA, o_fwdB;
    logic       o_stallIF, o_stallDEC, o_stallEXE, o_stallMEM;
    logic       o_flushDEC, o_flushEXE, o_flushMEM, o_flushWB;
    logic       o_mdBusy, o_mdDone, o_memErr;

    hazard_ctrl #(
        .MULT_LAT    (MUL_L),
        .DIV_LAT     (DIV_L),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .i_ra1       (i_ra1),
        .i_ra2       (i_ra2),
        .i_use1      (i_use1),
        .i_use2      (i_use2),
        .i_WRAE      (i_WRAE),
        .i_regWeE    (i_regWeE),
        .i_isLoadE   (i_isLoadE),
        .i_WRAM      (i_WRAM),
        .i_regWeM    (i_regWeM),
        .i_WRAW      (i_WRAW),
        .i_regWeW    (i_regWeW),
        .i_brTakenE  (i_brTakenE),
        .i_mdStartE  (i_mdStartE),
        .i_mdDivE    (i_mdDivE),
        .i_dMemReq   (i_dMemReq),
        .i_dMemReady (i_dMemReady),
        .o_fwdA      (o_fwdA),
        .o_fwdB      (o_fwdB),
        .o_stallIF   (o_stallIF),
        .o_stallDEC  (o_stallDEC),
        .o_stallEXE  (o_stallEXE),
        .o_stallMEM  (o_stallMEM),
        .o_flushDEC  (o_flushDEC),
        .o_flushEXE  (o_flushEXE),
        .o_flushMEM  (o_flushMEM),
        .o_flushWB   (o_flushWB),
        .o_mdBusy    (o_mdBusy),
        .o_mdDone    (o_mdDone),
        .o_memErr    (o_memErr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: m_age = cycles since a mult/div issued (-1 idle), m_len its occupancy.
    int m_age = -1;
    int m_len = 0;
    int m_wc  = 0;
    bit m_err = 1'b0;

    logic [14:0] dut_out;
    assign dut_out = {o_fwdA, o_fwdB, o_stallIF, o_stallDEC, o_stallEXE, o_stallMEM,
                      o_flushDEC, o_flushEXE, o_flushMEM, o_flushWB,
                      o_mdBusy, o_mdDone, o_memErr};

    function automatic logic [1:0] m_fwd(input logic [4:0] ra);
        if (ra == 5'd0)                              return 2'd0;
        if (i_regWeE && !i_isLoadE && i_WRAE == ra)  return 2'd1;
        if (i_regWeM && i_WRAM == ra)                return 2'd2;
        if (i_regWeW && i_WRAW == ra)                return 2'd3;
        return 2'd0;
    endfunction

    function automatic logic [14:0] model_out();
        bit ms, run, br, go, lu, md;
        if (rst) return 15'd0;
        ms  = i_dMemReq && !i_dMemReady;
        run = (m_age < 0);
        br  = run && i_brTakenE;
        go  = run && i_mdStartE && !i_brTakenE && !ms;
        lu  = run && i_isLoadE && (i_WRAE != 5'd0) && !i_brTakenE && !go &&
              ((i_use1 && i_ra1 == i_WRAE) || (i_use2 && i_ra2 == i_WRAE));
        md  = go || (m_age >= 1 && m_age <= m_len - 2);
        return {m_fwd(i_ra1), m_fwd(i_ra2),
                ms | md | lu, ms | md | lu, ms | md, ms,
                !ms && br, !ms && (br || lu), !ms && md, ms,
                m_age >= 1, m_age >= 1 && m_age == m_len - 1, m_err};
    endfunction

    always @(posedge clk) begin
        bit ms, go;
        if (rst) begin
            m_age = -1;
            m_wc  = 0;
            m_err = 1'b0;
        end else begin
            ms = i_dMemReq && !i_dMemReady;
            go = (m_age < 0) && i_mdStartE && !i_brTakenE && !ms;
            if (m_age >= 1) begin
                m_age = (m_age == m_len - 1) ? -1 : m_age + 1;
            end else if (go) begin
                m_age = 1;
                m_len = i_mdDivE ? DIV_L : MUL_L;
            end
            if (ms) begin
                m_wc++;
                if (m_wc >= TMO) m_err = 1'b1;
            end else begin
                m_wc = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [14:0] exp_v;
        exp_v = model_out();
        n_cmp++;
        if (dut_out !== exp_v) begin
            n_bad++;
            $display("FAIL model_cycle t=%0t dut=%b expected=%b", $time, dut_out, exp_v);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_ra1 = '0; i_ra2 = '0; i_use1 = 0; i_use2 = 0;
        i_WRAE = '0; i_regWeE = 0; i_isLoadE = 0;
        i_WRAM = '0; i_regWeM = 0; i_WRAW = '0; i_regWeW = 0;
        i_brTakenE = 0; i_mdStartE = 0; i_mdDivE = 0;
        i_dMemReq = 0; i_dMemReady = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_st;
        int done_at;

        // Reset with busy-looking inputs: everything must read 0.
        idle();
        rst = 1'b1;
        i_dMemReq = 1; i_ra1 = 5'd5; i_use1 = 1; i_WRAE = 5'd5; i_regWeE = 1; i_mdStartE = 1;
        settle(); chk("reset_outputs", 32'(dut_out), 32'd0);
        adv();
        settle(); chk("reset_outputs_hold", 32'(dut_out), 32'd0);
        adv();
        rst = 1'b0;
        idle();

        // Forwarding priority.
        i_ra1 = 5'd5; i_use1 = 1; i_WRAE = 5'd5; i_regWeE = 1; i_WRAM = 5'd5; i_regWeM = 1;
        i_ra2 = 5'd9; i_use2 = 1; i_WRAW = 5'd9; i_regWeW = 1;
        settle(); chk("fwd_exe", 32'(o_fwdA), 32'd1); chk("fwd_wb", 32'(o_fwdB), 32'd3);
        adv();
        i_regWeE = 0;
        settle(); chk("fwd_mem", 32'(o_fwdA), 32'd2);
        adv();
        i_regWeE = 1; i_isLoadE = 1;
        settle(); chk("fwd_load_skips_exe", 32'(o_fwdA), 32'd2);
        adv();
        idle();
        i_ra1 = 5'd0; i_use1 = 1; i_WRAE = 5'd0; i_regWeE = 1; i_WRAM = 5'd0; i_regWeM = 1;
        settle(); chk("fwd_r0", 32'(o_fwdA), 32'd0);
        adv();
        idle();

        // Load-use stall, then MEM forwarding next cycle.
        i_isLoadE = 1; i_WRAE = 5'd8; i_regWeE = 1; i_ra1 = 5'd8; i_use1 = 1;
        settle();
        chk("lu_stallIF", 32'(o_stallIF), 32'd1); chk("lu_stallDEC", 32'(o_stallDEC), 32'd1);
        chk("lu_flushEXE", 32'(o_flushEXE), 32'd1); chk("lu_stallEXE", 32'(o_stallEXE), 32'd0);
        adv();
        idle();
        i_ra1 = 5'd8; i_use1 = 1; i_WRAM = 5'd8; i_regWeM = 1;
        settle(); chk("lu_next_stall", 32'(o_stallIF), 32'd0); chk("lu_next_fwd", 32'(o_fwdA), 32'd2);
        adv();
        idle();
        i_isLoadE = 1; i_WRAE = 5'd8; i_regWeE = 1; i_ra1 = 5'd8; i_use1 = 0;
        settle(); chk("lu_unused_src", 32'(o_stallIF), 32'd0);
        adv();

        // Load-use overridden by a taken branch.
        i_use1 = 1; i_brTakenE = 1;
        settle();
        chk("br_lu_stallIF", 32'(o_stallIF), 32'd0); chk("br_flushDEC", 32'(o_flushDEC), 32'd1);
        chk("br_flushEXE", 32'(o_flushEXE), 32'd1);
        adv();
        idle();

        // Multiply, start held through the sequence (ignored while busy).
        i_mdStartE = 1; i_mdDivE = 0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("mul_stallEXE_%0d", k), 32'(o_stallEXE), (k < 3) ? 32'd1 : 32'd0);
            chk($sformatf("mul_done_%0d", k), 32'(o_mdDone), (k == 3) ? 32'd1 : 32'd0);
            chk($sformatf("mul_busy_%0d", k), 32'(o_mdBusy), (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
            adv();
            if (k == 3) i_mdStartE = 0;
        end

        // Divide: count stall cycles and the done cycle.
        n_st = 0; done_at = -1;
        i_mdStartE = 1; i_mdDivE = 1;
        for (int k = 0; k < 40; k++) begin
            settle();
            if (o_stallEXE) n_st++;
            if (o_mdDone && done_at < 0) done_at = k;
            adv();
            i_mdStartE = 0;
        end
        chk("div_stall_cycles", 32'(n_st), 32'd31);
        chk("div_done_cycle", 32'(done_at), 32'd31);
        idle();

        // Multiply with three dMem wait cycles during MD_WAIT.
        i_mdStartE = 1;
        for (int k = 0; k < 5; k++) begin
            i_dMemReq = (k >= 1 && k <= 3);
            settle();
            chk($sformatf("mdmem_stallMEM_%0d", k), 32'(o_stallMEM), (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
            chk($sformatf("mdmem_flushWB_%0d", k), 32'(o_flushWB), (k >= 1 && k <= 3) ? 32'd1 : 32'd0);
            chk($sformatf("mdmem_flushMEM_%0d", k), 32'(o_flushMEM), (k == 0) ? 32'd1 : 32'd0);
            chk($sformatf("mdmem_done_%0d", k), 32'(o_mdDone), (k == 3) ? 32'd1 : 32'd0);
            adv();
            i_mdStartE = 0;
        end
        idle();

        // Memory timeout: error after exactly TMO wait cycles, then sticky.
        i_dMemReq = 1;
        for (int k = 0; k < TMO; k++) begin
            settle();
            if (k == TMO - 1) chk("memerr_before", 32'(o_memErr), 32'd0);
            adv();
        end
        settle(); chk("memerr_set", 32'(o_memErr), 32'd1);
        adv();
        i_dMemReq = 0;
        adv(); adv();
        settle(); chk("memerr_sticky", 32'(o_memErr), 32'd1);
        adv();

        // Reset in the middle of a multiply.
        i_mdStartE = 1;
        settle();
        adv();
        i_mdStartE = 0;
        rst = 1'b1;
        settle(); chk("rst_mid_md", 32'(dut_out), 32'd0);
        adv();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            settle();
            chk($sformatf("rst_no_done_%0d", k), 32'(o_mdDone), 32'd0);
            chk($sformatf("rst_err_clr_%0d", k), 32'(o_memErr), 32'd0);
            adv();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and sequencing controller for the 5-stage MIPS core (IF/DEC/EXE/MEM/WB).
- Computes operand forwarding selects for the DEC read ports and detects load-use hazards.
- Squashes wrong-path instructions on taken branches.
- Sequences pipeline freezes for the multi-cycle mult/div unit and for data-memory wait states, and drives all stage stall/flush controls.

Parameters:
- MULT_LAT, 4: EXE occupancy of a multiply, in cycles (≥2).
- DIV_LAT, 32: EXE occupancy of a divide, in cycles (≥2).
- MEM_TIMEOUT, 255: consecutive dMem wait cycles before the error flag sets.

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- i_ra1, i_ra2  in  5 each  DEC source register addresses
- i_use1, i_use2  in  1 each  DEC instruction actually reads ra1 / ra2
- i_WRAE, i_regWeE, i_isLoadE  in  5/1/1  EXE destination, write enable, load flag
- i_WRAM, i_regWeM  in  5/1  MEM destination and write enable
- i_WRAW, i_regWeW  in  5/1  WB destination and write enable
- i_brTakenE  in  1  branch/jump resolved taken in EXE
- i_mdStartE, i_mdDivE  in  1/1  EXE issues a mult/div; 1 = divide
- i_dMemReq, i_dMemReady  in  1/1  MEM-stage access request and ready
- o_fwdA, o_fwdB  out  2 each  forward select: 0 = regfile, 1 = EXE aluOut, 2 = MEM data, 3 = WB result
- o_stallIF, o_stallDEC, o_stallEXE, o_stallMEM  out  1 each  hold the stage register
- o_flushDEC, o_flushEXE, o_flushMEM, o_flushWB  out  1 each  load a bubble into that stage
- o_mdBusy  out  1  mult/div sequence in progress
- o_mdDone  out  1  one-cycle pulse on mult/div completion
- o_memErr  out  1  sticky memory timeout flag

Behaviour:
- Reset: while rst is high, every output is 0, state = RUN, counters = 0. Reset mid-sequence aborts the sequence without an o_mdDone pulse.
- Forwarding (combinational), per operand:
  - Register 0 is never forwarded.
  - EXE match (regWeE, not a load) → 1; else MEM match → 2; else WB match → 3; else 0.
  - EXE has the highest priority.
- Load-use: i_isLoadE, i_WRAE≠0, and WRAE equals a used source → stallIF = stallDEC = 1 and flushEXE = 1 for one cycle. The following cycle forwards from MEM (2).
- Taken branch: i_brTakenE → flushDEC = flushEXE = 1. This overrides load-use (load-use stall forced 0). It is only effective when EXE advances.
- Memory wait (combinational): memStall = i_dMemReq & ~i_dMemReady → stallIF..stallMEM = 1, flushWB = 1. All flushes into DEC/EXE/MEM are suppressed that cycle. This has the highest priority.
- Wait counter:
  - Increments each memStall cycle and clears when memStall = 0.
  - On reaching MEM_TIMEOUT, o_memErr sets; it is cleared only by rst.
  - The counter saturates.
- State machine {RUN, MD_WAIT}:
  - RUN → MD_WAIT when i_mdStartE & ~i_brTakenE & ~memStall. On entry, load mdCnt = (i_mdDivE ? DIV_LAT : MULT_LAT) − 2.
  - In MD_WAIT:
    - o_mdBusy = 1.
    - stallIF/DEC/EXE = 1 and flushMEM = 1.
    - mdCnt decrements every cycle, including memStall cycles.
  - MD_WAIT with mdCnt = 0 → RUN; o_mdDone = 1 in that cycle and stalls released. Total EXE occupancy is exactly MULT_LAT / DIV_LAT cycles.
  - Any i_mdStartE seen while in MD_WAIT is ignored; it is the held instruction.
- Simultaneous events:
  - memStall outputs OR with MD_WAIT stalls.
  - flushMEM is forced 0 when memStall = 1.
  - Branch and load-use are evaluated only in RUN.

Decomposition:
- Shared package (cpu_pkg): forward-select encodings FWD_RF/EXE/MEM/WB, state encoding RUN/MD_WAIT, and default latency constants.
- One sub-module, fwd_sel: per-operand forwarding priority logic, instantiated twice (A, B).

Test Plan:
- ra1 = 5, use1; WRAE = 5, regWeE; WRAM = 5 → o_fwdA = 1. Remove the EXE match → 2. Set ra1 = 0 → 0.
- Load to r8 in EXE, DEC reads r8 → one cycle with stallIF/DEC = 1 and flushEXE = 1; the next cycle has no stall and fwd = 2.
- Load-use hazard and i_brTakenE in the same cycle → stalls 0, flushDEC = flushEXE = 1.
- i_mdStartE with i_mdDivE = 0 → stallEXE = 1 for 3 cycles; o_mdDone pulses in cycle 4. With divide → 31 stall cycles, done on cycle 32.
- i_dMemReq with ready low for 3 cycles during MD_WAIT → stallMEM = 1 and flushWB = 1 for those 3 cycles; MD completion timing unchanged.
- Ready held low for MEM_TIMEOUT cycles → o_memErr = 1 and stays set. Assert rst during MD_WAIT → all outputs 0 next cycle, no o_mdDone.
